// File: rtl/if_else_self_demod_277.sv
// If/else segment demodulator: Hamming-scores segments, decides bits, packs words.
// Optional low-confidence counter enabled by defining DEMOD_CONF_EN.
module if_else_self_demod_277 #(
  parameter int SEG_LEN     = 4,
  parameter int WORD_BITS   = 32,
  parameter int CONF_THRESH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync_clr,
  input  logic        seg_valid,
  output logic        seg_ready,
  input  logic [31:0] seg_data,
  input  logic [31:0] array_ref_wire,
  input  logic [31:0] array_ref_m_wire,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] word_data
`ifdef DEMOD_CONF_EN
  ,
  output logic [15:0] conf_err_cnt
`endif
);

  localparam int ACC_W  = $clog2(32 * SEG_LEN + 1);
  localparam int SCNT_W = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;
  localparam int BCNT_W = $clog2(WORD_BITS);

  if (SEG_LEN < 1 || WORD_BITS < 2 || WORD_BITS > 32 ||
      CONF_THRESH < 0) begin : g_bad_cfg
    $error("if_else_self_demod_277: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    STALL
  } state_e;

  state_e state_q, state_d;

  logic [SCNT_W-1:0]    samp_q, samp_d;
  logic [BCNT_W-1:0]    bit_q, bit_d;
  logic [WORD_BITS-2:0] shift_q, shift_d;
  logic [ACC_W-1:0]     acc_if_q, acc_if_d;
  logic [ACC_W-1:0]     acc_el_q, acc_el_d;
  logic [31:0]          word_q, word_d;
  logic                 wvalid_q, wvalid_d;

  logic                 accept;
  logic                 last_samp;
  logic                 last_bit;
  logic                 word_fin;
  logic                 stall;
  logic                 decide;
  logic                 word_load;
  logic [5:0]           d_if;
  logic [5:0]           d_el;
  logic [ACC_W-1:0]     base_if;
  logic [ACC_W-1:0]     base_el;
  logic [ACC_W-1:0]     tot_if;
  logic [ACC_W-1:0]     tot_el;
  logic                 bit_dec;
  logic [WORD_BITS-1:0] sh_full;
  logic [31:0]          word_ext;

  function automatic logic [5:0] pop32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  assign last_samp = (samp_q == SCNT_W'(SEG_LEN - 1));
  assign last_bit  = (bit_q == BCNT_W'(WORD_BITS - 1));
  assign word_fin  = last_samp & last_bit;
  assign stall     = word_fin & wvalid_q & ~word_ready;
  assign seg_ready = ~stall;
  assign accept    = seg_valid & seg_ready;
  assign decide    = accept & last_samp & ~sync_clr;
  assign word_load = decide & last_bit;

  assign d_if = pop32(seg_data ^ array_ref_wire);
  assign d_el = pop32(seg_data ^ array_ref_m_wire);

  // In IDLE the accumulators are known to be empty.
  assign base_if = (state_q == IDLE) ? '0 : acc_if_q;
  assign base_el = (state_q == IDLE) ? '0 : acc_el_q;
  assign tot_if  = base_if + ACC_W'(d_if);
  assign tot_el  = base_el + ACC_W'(d_el);
  assign bit_dec = (tot_if <= tot_el);
  assign sh_full = {shift_q, bit_dec};

  always_comb begin
    word_ext = '0;
    word_ext[31 -: WORD_BITS] = sh_full;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!sync_clr && accept) state_d = ACC;
      end
      ACC: begin
        if (sync_clr || (accept && word_fin)) state_d = IDLE;
        else if (stall)                        state_d = STALL;
      end
      STALL: begin
        if (sync_clr || (accept && word_fin)) state_d = IDLE;
        else if (!stall)                       state_d = ACC;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    samp_d   = samp_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    acc_if_d = acc_if_q;
    acc_el_d = acc_el_q;
    if (sync_clr) begin
      samp_d   = '0;
      bit_d    = '0;
      shift_d  = '0;
      acc_if_d = '0;
      acc_el_d = '0;
    end else if (accept) begin
      if (last_samp) begin
        samp_d   = '0;
        acc_if_d = '0;
        acc_el_d = '0;
        if (last_bit) begin
          bit_d   = '0;
          shift_d = '0;
        end else begin
          bit_d   = bit_q + BCNT_W'(1);
          shift_d = sh_full[WORD_BITS-2:0];
        end
      end else begin
        samp_d   = samp_q + SCNT_W'(1);
        acc_if_d = tot_if;
        acc_el_d = tot_el;
      end
    end
  end

  // A completing word may land in the same cycle the old one leaves.
  assign wvalid_d = word_load | (wvalid_q & ~word_ready);
  assign word_d   = word_load ? word_ext : word_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      samp_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      acc_if_q <= '0;
      acc_el_q <= '0;
      word_q   <= '0;
      wvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      samp_q   <= samp_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      acc_if_q <= acc_if_d;
      acc_el_q <= acc_el_d;
      word_q   <= word_d;
      wvalid_q <= wvalid_d;
    end
  end

  assign word_valid = wvalid_q;
  assign word_data  = word_q;

`ifdef DEMOD_CONF_EN
  localparam logic [31:0] CT = CONF_THRESH;

  logic [15:0]      conf_q, conf_d;
  logic [ACC_W-1:0] margin;

  assign margin = (tot_if >= tot_el) ? (tot_if - tot_el)
                                     : (tot_el - tot_if);

  always_comb begin
    conf_d = conf_q;
    if (decide && (32'(margin) < CT) && (conf_q != 16'hFFFF)) begin
      conf_d = conf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) conf_q <= '0;
    else        conf_q <= conf_d;
  end

  assign conf_err_cnt = conf_q;
`endif

endmodule

// File: tb/tb_if_else_self_demod_277.sv
// Directed bench for if_else_self_demod_277: vector table plus corner sequences.
// Define DEMOD_CONF_EN to also exercise the confidence counter.
module tb_if_else_self_demod_277;

  localparam logic [31:0] REF_IF = 32'hFFFF0000;
  localparam logic [31:0] REF_EL = 32'h0000FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sync_clr = 1'b0;
  logic        seg_valid = 1'b0;
  logic        seg_ready;
  logic [31:0] seg_data = '0;
  logic [31:0] array_ref_wire = REF_IF;
  logic [31:0] array_ref_m_wire = REF_EL;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic [31:0] word_data;
`ifdef DEMOD_CONF_EN
  logic [15:0] conf_err_cnt;
  logic [15:0] c0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_else_self_demod_277 dut (
    .clk              (clk),
    .reset            (reset),
    .sync_clr         (sync_clr),
    .seg_valid        (seg_valid),
    .seg_ready        (seg_ready),
    .seg_data         (seg_data),
    .array_ref_wire   (array_ref_wire),
    .array_ref_m_wire (array_ref_m_wire),
    .word_valid       (word_valid),
    .word_ready       (word_ready),
    .word_data        (word_data)
`ifdef DEMOD_CONF_EN
    ,
    .conf_err_cnt     (conf_err_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pat;
    logic [31:0] mask;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] seg_of(input logic [31:0] pat,
                                         input logic [31:0] mask,
                                         input int s);
    return (pat[31 - s / 4] ? REF_IF : REF_EL) ^ mask;
  endfunction

  task automatic send_seg(input logic [31:0] d);
    int n;
    n = 0;
    seg_valid = 1'b1;
    seg_data  = d;
    @(negedge clk);
    while (!seg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!seg_ready) begin
      checks++;
      errors++;
      $display("FAIL seg_timeout got=0 expected=1");
    end
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
  endtask

  task automatic send_range(input logic [31:0] pat, input logic [31:0] mask,
                            input int first, input int last);
    for (int s = first; s <= last; s++) begin
      send_seg(seg_of(pat, mask, s));
    end
  endtask

  task automatic send_word(input logic [31:0] pat, input logic [31:0] mask,
                           input logic [31:0] exp, input string nm);
    send_range(pat, mask, 0, 126);
    chk({nm, "_early"}, {31'd0, word_valid}, 32'd0);
    send_range(pat, mask, 127, 127);
    chk({nm, "_valid"}, {31'd0, word_valid}, 32'd1);
    chk({nm, "_data"}, word_data, exp);
  endtask

  task automatic drain();
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drained", {31'd0, word_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'hA5A50F0F, 32'h00000000, 32'hA5A50F0F};
    vecs[1] = '{32'h12345678, 32'h000000FF, 32'h12345678};
    vecs[2] = '{32'hDEADBEEF, 32'hFFFFFFFF, 32'h21524110};
    vecs[3] = '{32'h0F0F1234, 32'h0000FFFF, 32'hFFFFFFFF};

    #2 reset = 1'b0;
    #1;
    chk("rst_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_data", word_data, 32'd0);
    chk("rst_ready", {31'd0, seg_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      send_word(vecs[i].pat, vecs[i].mask, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // all-zero segments give a 16/16 tie per sample
    for (int s = 0; s < 4; s++) send_seg(32'h0);
    send_range(32'h0, 32'h0, 4, 126);
    chk("tie_early", {31'd0, word_valid}, 32'd0);
    send_range(32'h0, 32'h0, 127, 127);
    chk("tie_data", word_data, 32'h80000000);

    drain();
    word_ready = 1'b0;
    send_word(32'hA5A50F0F, 32'h0, 32'hA5A50F0F, "bp_w1");
    send_range(32'h5A5AF0F0, 32'h0, 0, 126);
    chk("bp_hold", word_data, 32'hA5A50F0F);
    seg_valid = 1'b1;
    seg_data  = seg_of(32'h5A5AF0F0, 32'h0, 127);
    @(negedge clk);
    chk("bp_stall", {31'd0, seg_ready}, 32'd0);
    @(negedge clk);
    chk("bp_stall2", {31'd0, seg_ready}, 32'd0);
    chk("bp_hold2", word_data, 32'hA5A50F0F);
    chk("bp_vld", {31'd0, word_valid}, 32'd1);
    word_ready = 1'b1;
    #1;
    chk("bp_release", {31'd0, seg_ready}, 32'd1);
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
    chk("bp_w2_valid", {31'd0, word_valid}, 32'd1);
    chk("bp_w2_data", word_data, 32'h5A5AF0F0);
    @(posedge clk);
    #1;
    chk("bp_done", {31'd0, word_valid}, 32'd0);

    send_range(32'h13572468, 32'h0, 0, 49);
    seg_valid = 1'b1;
    seg_data  = seg_of(32'h13572468, 32'h0, 50);
    sync_clr  = 1'b1;
    @(negedge clk);
    chk("clr_ready", {31'd0, seg_ready}, 32'd1);
    @(posedge clk);
    #1;
    sync_clr  = 1'b0;
    seg_valid = 1'b0;
    send_word(32'h3C3CA5A5, 32'h0, 32'h3C3CA5A5, "clr");

    drain();
    send_range(32'hC0FFEE00, 32'h0, 0, 59);
    reset = 1'b0;
    #1;
    chk("rmid_valid", {31'd0, word_valid}, 32'd0);
    chk("rmid_data", word_data, 32'd0);
    chk("rmid_ready", {31'd0, seg_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_word(32'h600DF00D, 32'h0, 32'h600DF00D, "rmid");

    drain();
    word_ready = 1'b0;
    send_word(32'h11112222, 32'h0, 32'h11112222, "rst_w1");
    send_range(32'h33334444, 32'h0, 0, 126);
    seg_valid = 1'b1;
    seg_data  = seg_of(32'h33334444, 32'h0, 127);
    @(negedge clk);
    chk("rstall_ready", {31'd0, seg_ready}, 32'd0);
    #1 reset = 1'b0;
    #1;
    chk("rstall_valid", {31'd0, word_valid}, 32'd0);
    chk("rstall_data", word_data, 32'd0);
    chk("rstall_rdy", {31'd0, seg_ready}, 32'd1);
    seg_valid  = 1'b0;
    word_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_word(32'h0BADCAFE, 32'h0, 32'h0BADCAFE, "rstall");
    drain();

`ifdef DEMOD_CONF_EN
    array_ref_wire   = 32'h00000000;
    array_ref_m_wire = 32'h00000007;
    c0 = conf_err_cnt;
    // d_if=15, d_el=16 per sample: totals 60 vs 64
    for (int s = 0; s < 4; s++) send_seg(32'h3FFF0001);
    chk("conf_inc", {16'd0, conf_err_cnt}, {16'd0, c0 + 16'd1});
    force dut.conf_q = 16'hFFFF;
    #1;
    release dut.conf_q;
    for (int s = 0; s < 4; s++) send_seg(32'h3FFF0001);
    chk("conf_sat", {16'd0, conf_err_cnt}, 32'h0000FFFF);
    array_ref_wire   = REF_IF;
    array_ref_m_wire = REF_EL;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
